// File: rtl/fir_stream_ctrl.sv
// Stream controller for a FIR datapath: buffers upstream samples, issues one
// sample per sample-rate tick, flushes the filter on drain and returns results.
module fir_stream_ctrl #(
   parameter int DATA_W     = 16,
   parameter int ACC_W      = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_W      = 8,
   parameter int PIPE_LAT   = 4,
   parameter int FLUSH_LEN  = 17
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic              clr,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic [DATA_W-1:0] fir_data,
   output logic              buff_en,
   output logic              fir_en,
   input  logic [ACC_W-1:0]  fir_filtered_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [ACC_W-1:0]  m_data,
   output logic              busy,
   output logic              ovf,
   output logic [7:0]        underrun_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = $clog2(FLUSH_LEN + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [DIV_W-1:0]  div_lim;
   logic [DIV_W-1:0]  div_cnt;
   logic              tick;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;

   logic [FW-1:0]     flush_cnt;
   logic              flush_done;
   logic              issue_val;
   logic              issue_zero;
   logic              urun_evt;

   logic [PIPE_LAT-2:0] tok;
   logic [PIPE_LAT-1:0] pipe;
   logic [PIPE_LAT-2:0] tok_nxt;
   logic                cap;
   logic                drain_done;
   logic                ovf_evt;

   assign full    = (count == (AW+1)'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign s_ready = !full && (state != ST_DRAIN);
   assign push    = s_valid && s_ready;

   assign flush_done = (flush_cnt == FW'(FLUSH_LEN));

   // The token pipe's bit0 is the buff_en register itself; the top bit marks the capture cycle.
   assign pipe    = {tok, buff_en};
   assign tok_nxt = pipe[PIPE_LAT-2:0];
   assign cap     = pipe[PIPE_LAT-1];
   assign ovf_evt = cap && m_valid && !m_ready;

   // Drain ends once the pipe will be empty after this edge, so busy drops PIPE_LAT cycles after the last strobe.
   assign drain_done = empty && flush_done && (tok_nxt == '0) && !issue_val;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; run is ignored while draining.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (run) state_nxt = ST_RUN;     else state_nxt = ST_IDLE;
         ST_RUN:   if (!run) state_nxt = ST_DRAIN;  else state_nxt = ST_RUN;
         ST_DRAIN: if (drain_done) state_nxt = ST_IDLE; else state_nxt = ST_DRAIN;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Tick decode and per-tick issue decision.
   always_comb begin
      tick       = (state != ST_IDLE) && (div_cnt == div_lim);
      pop        = 1'b0;
      issue_val  = 1'b0;
      issue_zero = 1'b0;
      urun_evt   = 1'b0;
      if (tick) begin
         if (!empty) begin
            pop       = 1'b1;
            issue_val = 1'b1;
         end else if (state == ST_RUN) begin
            urun_evt = 1'b1;
         end else if (!flush_done) begin
            issue_val  = 1'b1;
            issue_zero = 1'b1;
         end else begin
            issue_val = 1'b0;
         end
      end else begin
         pop = 1'b0;
      end
   end

   // Sample-rate divider; the limit is only taken while idle with run low.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_lim <= '0;
         div_cnt <= '0;
      end else begin
         if ((state == ST_IDLE) && !run) begin
            div_lim <= cfg_div;
         end
         if ((state == ST_IDLE) || tick) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

   // FIFO storage.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= s_data;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Zero-sample counter for the flush; rearmed whenever idle.
   always_ff @(posedge clk) begin
      if (reset || (state == ST_IDLE)) begin
         flush_cnt <= '0;
      end else if (issue_zero) begin
         flush_cnt <= flush_cnt + FW'(1);
      end
   end

   // Registered issue to the filter; fir_data holds between strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         buff_en  <= 1'b0;
         fir_data <= '0;
      end else begin
         buff_en <= issue_val;
         if (issue_val) begin
            fir_data <= issue_zero ? '0 : mem[rd_ptr];
         end
      end
   end

   // Token pipe and registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         tok    <= '0;
         busy   <= 1'b0;
         fir_en <= 1'b0;
      end else begin
         tok    <= tok_nxt;
         busy   <= (state_nxt != ST_IDLE);
         fir_en <= (state_nxt != ST_IDLE) || (tok_nxt != '0) || issue_val;
      end
   end

   // Result capture; a capture always wins over an accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_valid <= 1'b0;
         m_data  <= '0;
      end else if (cap) begin
         m_valid <= 1'b1;
         m_data  <= fir_filtered_data;
      end else if (m_valid && m_ready) begin
         m_valid <= 1'b0;
      end
   end

   // Sticky overwrite flag and saturating underrun counter; events beat clr.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf          <= 1'b0;
         underrun_cnt <= 8'd0;
      end else begin
         if (ovf_evt) begin
            ovf <= 1'b1;
         end else if (clr) begin
            ovf <= 1'b0;
         end
         if (clr) begin
            underrun_cnt <= urun_evt ? 8'd1 : 8'd0;
         end else if (urun_evt && (underrun_cnt != 8'd255)) begin
            underrun_cnt <= underrun_cnt + 8'd1;
         end
      end
   end

endmodule
